// File: rtl/card_read_pkg.sv
// Shared types and helpers for the card-read cycle controller.
package card_read_pkg;

    typedef enum logic [1:0] {IDLE, LATCH, ROWS, TAIL} rd_state_t;

    localparam logic [3:0] ROWS_PER_CARD = 4'd12;

    // Rows are read face-down, so counter order maps to names 9..0, then 11, 12.
    function automatic logic [3:0] row_name(input logic [3:0] cnt);
        if (cnt < 4'd10)
            row_name = 4'd9 - cnt;
        else if (cnt == 4'd10)
            row_name = 4'd11;
        else
            row_name = 4'd12;
    endfunction

endpackage

// File: rtl/edge_det.sv
// One-bit registered edge detector; the reset value sets the assumed resting level.
module edge_det #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic rise,
    output logic fall
);

    logic q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            q <= RESET_VAL;
        else
            q <= d;
    end

    assign rise = d & ~q;
    assign fall = ~d & q;

endmodule

// File: rtl/card_read_ctrl.sv
// Card-read cycle controller: requests feed cycles, frames them from the shaft
// contacts and delivers the 12 brush rows in reading order.
module card_read_ctrl
    import card_read_pkg::*;
#(
    parameter int NUM_COLS = 80,
    parameter int CNT_W    = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                read_call,
    input  logic                rl10,
    input  logic                sccb,
    input  logic [NUM_COLS-1:0] brushes,
    output logic                clch_latch,
    output logic                busy,
    output logic                row_valid,
    output logic [3:0]          row_num,
    output logic [NUM_COLS-1:0] row_data,
    output logic                card_done,
    output logic                row_error,
    output logic [CNT_W-1:0]    cards_read
);

    rd_state_t  state;
    rd_state_t  state_next;
    logic [3:0] row_cnt;
    logic [3:0] row_cnt_next;
    logic       capture;
    logic       finish;
    logic       err_set;
    logic       sccb_rise;
    logic       sccb_fall_unused;
    logic       rl10_rise;
    logic       rl10_fall;

    // The shaft rests at 315 degrees, where both contacts are closed.
    edge_det #(.RESET_VAL(1'b1)) u_sccb_edge (
        .clk   (clk),
        .reset (reset),
        .d     (sccb),
        .rise  (sccb_rise),
        .fall  (sccb_fall_unused)
    );

    edge_det #(.RESET_VAL(1'b1)) u_rl10_edge (
        .clk   (clk),
        .reset (reset),
        .d     (rl10),
        .rise  (rl10_rise),
        .fall  (rl10_fall)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next   = state;
        row_cnt_next = row_cnt;
        capture      = 1'b0;
        finish       = 1'b0;
        err_set      = 1'b0;
        case (state)
            IDLE: begin
                if (read_call)
                    state_next = LATCH;
            end
            LATCH: begin
                if (rl10_fall) begin
                    state_next   = ROWS;
                    row_cnt_next = 4'd0;
                end
            end
            ROWS: begin
                if (sccb_rise && (row_cnt < ROWS_PER_CARD)) begin
                    capture      = 1'b1;
                    row_cnt_next = row_cnt + 4'd1;
                end
                if (row_cnt_next == ROWS_PER_CARD)
                    state_next = TAIL;
                // A late strobe on the closing edge still counts before judging shortness.
                if (rl10_rise) begin
                    finish     = 1'b1;
                    err_set    = (row_cnt_next < ROWS_PER_CARD);
                    state_next = read_call ? LATCH : IDLE;
                end
            end
            TAIL: begin
                if (rl10_rise) begin
                    finish     = 1'b1;
                    state_next = read_call ? LATCH : IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            row_cnt    <= 4'd0;
            row_valid  <= 1'b0;
            row_num    <= 4'd0;
            row_data   <= '0;
            card_done  <= 1'b0;
            row_error  <= 1'b0;
            cards_read <= '0;
        end else begin
            row_cnt   <= row_cnt_next;
            row_valid <= capture;
            card_done <= finish;
            if (capture) begin
                row_data <= brushes;
                row_num  <= row_name(row_cnt);
            end
            if (err_set)
                row_error <= 1'b1;
            if (finish)
                cards_read <= cards_read + 1'b1;
        end
    end

    // Holding the latch through TAIL lets the clutch re-engage at 315 degrees.
    assign clch_latch = (state == LATCH) || ((state == TAIL) && read_call);
    assign busy       = (state != IDLE);

endmodule

// File: tb/tb_card_read_ctrl.sv
// Randomized self-checking bench: drives shaft contacts directly and checks rows
// and card completions against an event-level model of the card cycle.
module tb_card_read_ctrl;

    localparam int NUM_COLS = 80;
    localparam int CNT_W    = 16;

    typedef struct {
        logic [3:0]          num;
        logic [NUM_COLS-1:0] data;
    } row_t;

    logic                clk = 1'b0;
    logic                reset;
    logic                read_call;
    logic                rl10;
    logic                sccb;
    logic [NUM_COLS-1:0] brushes;
    logic                clch_latch;
    logic                busy;
    logic                row_valid;
    logic [3:0]          row_num;
    logic [NUM_COLS-1:0] row_data;
    logic                card_done;
    logic                row_error;
    logic [CNT_W-1:0]    cards_read;

    int   vectors     = 0;
    int   miscompares = 0;
    int   doneCount   = 0;
    int   expDone     = 0;
    int   expCards    = 0;
    bit   expErr      = 1'b0;
    bit   contRun     = 1'b0;
    row_t expRows[$];
    row_t monRow;
    int   rowNames[12] = '{9, 8, 7, 6, 5, 4, 3, 2, 1, 0, 11, 12};
    logic [NUM_COLS-1:0] parityA;

    card_read_ctrl #(.NUM_COLS(NUM_COLS), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .read_call  (read_call),
        .rl10       (rl10),
        .sccb       (sccb),
        .brushes    (brushes),
        .clch_latch (clch_latch),
        .busy       (busy),
        .row_valid  (row_valid),
        .row_num    (row_num),
        .row_data   (row_data),
        .card_done  (card_done),
        .row_error  (row_error),
        .cards_read (cards_read)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [NUM_COLS-1:0] randBrushes();
        logic [95:0] r;
        r = {$urandom, $urandom, $urandom};
        return r[NUM_COLS-1:0];
    endfunction

    // Rows come out in the order the strobes arrive, each holding the brushes seen at its rise.
    always @(negedge clk) begin
        if (!reset) begin
            if (row_valid) begin
                if (expRows.size() == 0)
                    checkOutput("rowExtra", 1, 0);
                else begin
                    monRow = expRows.pop_front();
                    checkOutput("rowNum", row_num, monRow.num);
                    checkOutput("rowData", row_data, monRow.data);
                end
            end
            if (card_done)
                doneCount++;
            if (contRun)
                checkOutput("busyCont", busy, 1);
        end
    end

    task automatic ignoredStrobes(input int n);
        repeat (n) begin
            sccb = 1'b1;
            step(2);
            sccb = 1'b0;
            step(2);
        end
    endtask

    task automatic applyStimulus(input int nStrobes, input bit coincide, input bit keepCall,
                                 input bit fromIdle, input bit parity);
        if (fromIdle) begin
            checkOutput("idleBusy", busy, 0);
            read_call = 1'b1;
            checkOutput("idleLatch", clch_latch, 0);
            step(1);
            checkOutput("latchReq", clch_latch, 1);
            checkOutput("latchBusy", busy, 1);
        end
        contRun = keepCall;
        ignoredStrobes($urandom_range(0, 2));
        if (!keepCall)
            read_call = 1'b0;
        step(1);
        checkOutput("latchHold", clch_latch, 1);
        rl10 = 1'b0;
        step(1);
        for (int i = 0; i < nStrobes; i++) begin
            step($urandom_range(1, 4));
            if (parity) begin
                if (i == 0)
                    brushes = parityA;
                else if (i == 11)
                    brushes = ~parityA;
            end else
                brushes = randBrushes();
            sccb = 1'b1;
            if (coincide && (i == nStrobes - 1))
                rl10 = 1'b1;
            expRows.push_back('{num: 4'(rowNames[i]), data: brushes});
            step(1);
            if (!parity)
                brushes = randBrushes();
            step(1);
            sccb = 1'b0;
        end
        if (!coincide) begin
            step($urandom_range(1, 3));
            if (nStrobes == 12)
                ignoredStrobes($urandom_range(0, 2));
            rl10 = 1'b1;
            step(1);
        end
        expDone++;
        expCards++;
        if (nStrobes < 12)
            expErr = 1'b1;
        step(2);
        checkOutput("doneCount", doneCount, expDone);
        checkOutput("cardsRead", cards_read, expCards);
        checkOutput("rowError", row_error, expErr);
        checkOutput("rowsLeft", expRows.size(), 0);
        checkOutput("busyAfter", busy, keepCall);
        checkOutput("latchAfter", clch_latch, keepCall);
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, ".clch"}, clch_latch, 0);
        checkOutput({tag, ".busy"}, busy, 0);
        checkOutput({tag, ".rowValid"}, row_valid, 0);
        checkOutput({tag, ".rowNum"}, row_num, 0);
        checkOutput({tag, ".rowData"}, row_data, 0);
        checkOutput({tag, ".cardDone"}, card_done, 0);
        checkOutput({tag, ".rowError"}, row_error, 0);
        checkOutput({tag, ".cardsRead"}, cards_read, 0);
    endtask

    initial begin
        reset     = 1'b1;
        read_call = 1'b0;
        rl10      = 1'b1;
        sccb      = 1'b0;
        brushes   = '0;
        for (int c = 0; c < NUM_COLS; c++)
            parityA[c] = c[0];
        step(3);
        checkResetValues("reset");
        reset = 1'b0;
        step(2);

        $display("[TB] single card");
        applyStimulus(12, 1'b0, 1'b0, 1'b1, 1'b0);

        $display("[TB] continuous run");
        applyStimulus(12, 1'($urandom_range(0, 1)), 1'b1, 1'b1, 1'b0);
        applyStimulus(12, 1'($urandom_range(0, 1)), 1'b1, 1'b0, 1'b0);
        applyStimulus(12, 1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0);

        $display("[TB] parity data");
        applyStimulus(12, 1'b0, 1'b0, 1'b1, 1'b1);

        $display("[TB] short cycle");
        applyStimulus(5, 1'b0, 1'b0, 1'b1, 1'b0);

        $display("[TB] random cards");
        for (int k = 0; k < 6; k++)
            applyStimulus($urandom_range(1, 12), 1'($urandom_range(0, 1)), 1'b0, 1'b1, 1'b0);

        $display("[TB] reset mid-cycle");
        read_call = 1'b1;
        step(1);
        read_call = 1'b0;
        rl10 = 1'b0;
        step(1);
        for (int i = 0; i < 4; i++) begin
            step($urandom_range(1, 4));
            brushes = randBrushes();
            sccb = 1'b1;
            expRows.push_back('{num: 4'(rowNames[i]), data: brushes});
            step(2);
            sccb = 1'b0;
        end
        step(2);
        checkOutput("midRows", expRows.size(), 0);
        reset = 1'b1;
        #1;
        checkResetValues("midReset");
        expRows.delete();
        expCards = 0;
        expErr   = 1'b0;
        step(2);
        rl10  = 1'b1;
        sccb  = 1'b0;
        reset = 1'b0;
        step(2);
        checkOutput("noPartialDone", doneCount, expDone);
        applyStimulus(12, 1'b0, 1'b0, 1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/card_read_ctrl.md
# card_read_ctrl

Card-read cycle controller: the consumer side of the clutch/cam assembly. It requests feed cycles by driving `clch_latch`. It decodes the clutched-shaft contacts `rl10` and `sccb` to frame each card cycle, samples the 80 read-brush lines on each of the 12 row strobes, and presents the rows in order (9…0, 11, 12) to the downstream reader buffer logic. It sits between the feed request logic and the clutch/cam assembly and brush model.

## Interface
- `NUM_COLS`, 80: brush columns sampled per row.
- `CNT_W`, 16: width of the cards-read counter.

- `clk`  in  1  simulation clock, same clock that advances the shaft angles.
- `reset`  in  1  asynchronous, active-high reset.
- `read_call`  in  1  level request for card feed cycles; held high for continuous feeding.
- `rl10`  in  1  clutched-shaft contact, high for clutched angles 272–341.
- `sccb`  in  1  row strobe, 12 two-cycle pulses per clutched revolution.
- `brushes`  in  NUM_COLS  read-brush contacts, 1 = hole.
- `clch_latch`  out  1  clutch latch request.
- `busy`  out  1  high in any state other than IDLE.
- `row_valid`  out  1  one-cycle pulse, `row_data` and `row_num` valid.
- `row_num`  out  4  row name: 9..0, or 11, or 12.
- `row_data`  out  NUM_COLS  brush sample for the row.
- `card_done`  out  1  one-cycle pulse at end of card cycle.
- `row_error`  out  1  sticky; set when a cycle ends with fewer than 12 strobes; cleared only by reset.
- `cards_read`  out  CNT_W  count of completed cycles; wraps at 2^CNT_W.

## Operation
- **Edge detection**
  - `sccb` and `rl10` are registered into `sccb_q` and `rl10_q`. Both reset to 1 (shaft rests at 315°).
  - Rise = `x & ~x_q`. Fall = `~x & x_q`.
- **IDLE**
  - `clch_latch` = 0.
  - Go to LATCH when `read_call` = 1.
- **LATCH**
  - `clch_latch` = 1 regardless of `read_call`.
  - Go to ROWS on `rl10` fall, i.e. the clutched shaft has passed 342°.
  - Clear the row counter (0..12, 4 bits) on that transition.
- **ROWS**
  - `clch_latch` = 0.
  - On each `sccb` rise with row counter < 12:
    - capture `brushes` into `row_data`;
    - set `row_num` from the counter (counter 0→9, 1→8, … 9→0, 10→11, 11→12);
    - pulse `row_valid`;
    - increment the counter.
  - Go to TAIL when the counter reaches 12.
  - An `rl10` rise in ROWS: set `row_error`, then take the TAIL exit actions immediately.
- **TAIL**
  - `clch_latch` = `read_call`, so the latch is sampled at 315° for back-to-back feeding.
  - On `rl10` rise:
    - pulse `card_done`;
    - increment `cards_read`;
    - go to LATCH if `read_call` = 1, else IDLE.
- **Ignored and simultaneous events**
  - `sccb` edges in IDLE, LATCH and TAIL are ignored.
  - `read_call` dropping in LATCH or ROWS does not abort the cycle.
  - `sccb` rise and `rl10` rise on the same edge in ROWS: capture the row first, then apply the `rl10` rule; `row_error` is set only if the counter after capture is < 12.

## Timing
- Reset values:
  - state IDLE;
  - `clch_latch`, `busy`, `row_valid`, `card_done`, `row_error` = 0;
  - `row_num` = 0, `row_data` = 0, `cards_read` = 0.
- Reset asserted mid-cycle returns to IDLE immediately. A partial card produces no `card_done`.
- All outputs are registered except `clch_latch` and `busy`, which decode the current state.
- Latencies:
  - `row_valid` is high in the cycle after the clock edge that sees `sccb` = 1 with `sccb_q` = 0, for exactly 1 cycle per strobe.
  - `card_done` is high for 1 cycle, one cycle after the `rl10` rise is sampled.
  - From `read_call` high in IDLE, `clch_latch` goes high on the next edge.
- Continuous feeding yields exactly 12 `row_valid` pulses and 1 `card_done` per 360 shaft clocks.

## Structure
- Package `card_read_pkg` holds:
  - state enum `rd_state_t` {IDLE, LATCH, ROWS, TAIL};
  - `ROWS_PER_CARD` = 12;
  - the counter→row-name lookup function.
- Sub-module `edge_det`: one-bit registered edge detector with outputs `rise` and `fall`, and a reset value parameter. It is instantiated twice, once for `sccb` and once for `rl10`.

## Test plan
- **Single card:** connect to the clutch/cam assembly and pulse `read_call` high for 10 cycles from rest.
  - Required: 12 `row_valid` pulses with `row_num` sequence 9,8,7,6,5,4,3,2,1,0,11,12.
  - Then 1 `card_done`, `cards_read` = 1, return to IDLE, `clch_latch` low.
- **Continuous run:** hold `read_call` high for 3 cards.
  - Required: 36 `row_valid` pulses, 3 `card_done` pulses 360 clocks apart, `cards_read` = 3.
  - `busy` never drops between cards.
- **Data capture:** drive `brushes` = column index parity pattern, changing only at the 9-row and 12-row strobes.
  - Required: `row_data` matches the pattern present at each `sccb` rise.
- **Short cycle:** direct-drive the inputs, issue only 5 `sccb` pulses, then an `rl10` rise.
  - Required: `row_error` = 1, one `card_done`, `cards_read` = 1.
- **Reset mid-cycle:** assert `reset` after row 4.
  - Required: all outputs at reset values the same cycle, no `card_done`.
  - A new `read_call` then yields a full 12-row card.
